// File: rtl/dino_game_ctrl_if.sv
// Board-side and sprite-side signal bundle for dino_game_ctrl.
// slave = the controller; master = whatever drives buttons, strobe and boxes.
interface dino_game_ctrl_if;
  logic        i_ani_stb;
  logic        i_btn_jump;
  logic        i_btn_duck;
  logic [11:0] i_dino_x1, i_dino_x2, i_dino_y1, i_dino_y2;
  logic [11:0] i_obs_x1, i_obs_x2, i_obs_y1, i_obs_y2;
  logic        o_animate;
  logic        o_game_rst;
  logic        o_jump;
  logic        o_duck;
  logic [15:0] o_score;
  logic [3:0]  o_speed;
  logic [1:0]  o_state;
  logic        o_game_over;
  logic [15:0] o_hiscore;

  modport slave (
    input  i_ani_stb, i_btn_jump, i_btn_duck,
    input  i_dino_x1, i_dino_x2, i_dino_y1, i_dino_y2,
    input  i_obs_x1, i_obs_x2, i_obs_y1, i_obs_y2,
    output o_animate, o_game_rst, o_jump, o_duck, o_score, o_speed,
    output o_state, o_game_over, o_hiscore
  );

  modport master (
    output i_ani_stb, i_btn_jump, i_btn_duck,
    output i_dino_x1, i_dino_x2, i_dino_y1, i_dino_y2,
    output i_obs_x1, i_obs_x2, i_obs_y1, i_obs_y2,
    input  o_animate, o_game_rst, o_jump, o_duck, o_score, o_speed,
    input  o_state, o_game_over, o_hiscore
  );
endinterface

// File: rtl/dino_game_ctrl.sv
// Chrome-dino game sequencer: button sync, IDLE/RUN/HIT/OVER flow, collision, score, speed.
// Optional best-score register enabled by defining DINO_HISCORE_EN.
module dino_game_ctrl #(
  parameter int SCORE_DIV  = 6,
  parameter int SPEED_STEP = 100,
  parameter int SPEED_INIT = 2,
  parameter int SPEED_MAX  = 15,
  parameter int HIT_FRAMES = 30
) (
  input  logic             i_clk,
  input  logic             i_rst,
  dino_game_ctrl_if.slave  bus
);
  localparam int FW = (SCORE_DIV  > 1) ? $clog2(SCORE_DIV)  : 1;
  localparam int SW = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
  localparam int HW = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HIT = 2'd2, OVER = 2'd3} state_e;

  state_e        state_q, state_d;
  logic          jmp_s1_q, jmp_s2_q, jmp_s3_q;
  logic          duck_s1_q, duck_s2_q;
  logic [FW-1:0] frame_q, frame_d;
  logic [SW-1:0] step_q, step_d;
  logic [HW-1:0] hit_q, hit_d;
  logic [15:0]   score_q, score_d;
  logic [3:0]    speed_q, speed_d;
  logic          game_rst_q, game_rst_d;
  logic          jump_q, jump_d;
  logic          jump_edge, collide;

  assign jump_edge = jmp_s2_q & ~jmp_s3_q;
  // Strict overlap: boxes that only share an edge do not collide.
  assign collide = (bus.i_dino_x1 < bus.i_obs_x2) && (bus.i_obs_x1 < bus.i_dino_x2) &&
                   (bus.i_dino_y1 < bus.i_obs_y2) && (bus.i_obs_y1 < bus.i_dino_y2);

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    step_d     = step_q;
    hit_d      = hit_q;
    score_d    = score_q;
    speed_d    = speed_q;
    game_rst_d = 1'b0;
    jump_d     = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (jump_edge) begin
          state_d    = RUN;
          game_rst_d = 1'b1;
          frame_d    = '0;
          step_d     = '0;
          score_d    = '0;
          speed_d    = 4'(SPEED_INIT);
        end
      end
      RUN: begin
        if (bus.i_ani_stb && collide) begin
          state_d = HIT;
          hit_d   = '0;
        end else begin
          jump_d = jump_edge;
          if (bus.i_ani_stb) begin
            if (frame_q == FW'(SCORE_DIV - 1)) begin
              frame_d = '0;
              if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
              if (step_q == SW'(SPEED_STEP - 1)) begin
                step_d = '0;
                if (speed_q != 4'(SPEED_MAX)) speed_d = speed_q + 4'd1;
              end else begin
                step_d = step_q + SW'(1);
              end
            end else begin
              frame_d = frame_q + FW'(1);
            end
          end
        end
      end
      HIT: begin
        if (bus.i_ani_stb) begin
          if (hit_q == HW'(HIT_FRAMES - 1)) state_d = OVER;
          else hit_d = hit_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      jmp_s1_q   <= 1'b0;
      jmp_s2_q   <= 1'b0;
      jmp_s3_q   <= 1'b0;
      duck_s1_q  <= 1'b0;
      duck_s2_q  <= 1'b0;
      frame_q    <= '0;
      step_q     <= '0;
      hit_q      <= '0;
      score_q    <= '0;
      speed_q    <= 4'(SPEED_INIT);
      game_rst_q <= 1'b0;
      jump_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      jmp_s1_q   <= bus.i_btn_jump;
      jmp_s2_q   <= jmp_s1_q;
      jmp_s3_q   <= jmp_s2_q;
      duck_s1_q  <= bus.i_btn_duck;
      duck_s2_q  <= duck_s1_q;
      frame_q    <= frame_d;
      step_q     <= step_d;
      hit_q      <= hit_d;
      score_q    <= score_d;
      speed_q    <= speed_d;
      game_rst_q <= game_rst_d;
      jump_q     <= jump_d;
    end
  end

  assign bus.o_state     = state_q;
  assign bus.o_animate   = (state_q == RUN);
  assign bus.o_duck      = (state_q == RUN) && duck_s2_q;
  assign bus.o_game_over = (state_q == OVER);
  assign bus.o_jump      = jump_q;
  assign bus.o_game_rst  = game_rst_q;
  assign bus.o_score     = score_q;
  assign bus.o_speed     = speed_q;

`ifdef DINO_HISCORE_EN
  logic        over_q;
  logic [15:0] hiscore_q;

  // Latch the best score on the cycle after OVER is entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      over_q    <= 1'b0;
      hiscore_q <= '0;
    end else begin
      over_q <= (state_q == OVER);
      if ((state_q == OVER) && !over_q && (score_q > hiscore_q)) hiscore_q <= score_q;
    end
  end
  assign bus.o_hiscore = hiscore_q;
`else
  assign bus.o_hiscore = '0;
`endif
endmodule

// File: doc/dino_game_ctrl.md
# dino_game_ctrl

Game-level sequencer for the Chrome-dino design. It synchronises the jump and duck buttons and issues clean one-cycle jump pulses. It gates the animation enable of the dinosaur and obstacle sprite blocks, detects dino/obstacle bounding-box collisions on each frame strobe, and keeps score and scroll speed. It sits between the board buttons and the sprite blocks, and drives their `i_animate`, `i_rst`, `i_jump` and `i_duck` inputs.

## Interface
- `SCORE_DIV`, 6: frame strobes per score point.
- `SPEED_STEP`, 100: score points per speed increment.
- `SPEED_INIT`, 2: speed after game reset.
- `SPEED_MAX`, 15: speed saturation value.
- `HIT_FRAMES`, 30: frame strobes spent in HIT before OVER.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_ani_stb`  in  1  one-cycle frame strobe.
- `i_btn_jump`  in  1  raw asynchronous jump button.
- `i_btn_duck`  in  1  raw asynchronous duck button.
- `i_dino_x1`, `i_dino_x2`, `i_dino_y1`, `i_dino_y2`  in  12 each  dino bounding box.
- `i_obs_x1`, `i_obs_x2`, `i_obs_y1`, `i_obs_y2`  in  12 each  obstacle bounding box.
- `o_animate`  out  1  sprite animation enable.
- `o_game_rst`  out  1  one-cycle sprite reset pulse.
- `o_jump`  out  1  one-cycle qualified jump pulse.
- `o_duck`  out  1  qualified duck level.
- `o_score`  out  16  binary score.
- `o_speed`  out  4  obstacle scroll speed, in px/frame.
- `o_state`  out  2  state: IDLE=0, RUN=1, HIT=2, OVER=3.
- `o_game_over`  out  1  high in OVER.
- `o_hiscore`  out  16  best score (see Configuration).

## Operation
- **Button conditioning**
  - Each button passes through a 2-flop synchroniser.
  - `jump_edge` is the rising edge of the synchronised jump button, one cycle wide.
- **IDLE**
  - `o_animate`=0.
  - `jump_edge` → pulse `o_game_rst`, clear score and frame counters, set speed=`SPEED_INIT`, go to RUN.
- **RUN**
  - `o_animate`=1.
  - `o_jump`=`jump_edge`.
  - `o_duck`=synchronised duck level.
  - On each `i_ani_stb`, first evaluate collision as strict overlap:
    - `dx1<ox2 && ox1<dx2 && dy1<oy2 && oy1<dy2`, all compared unsigned.
    - Collision → go to HIT. No score or speed update on that strobe.
  - Otherwise, advance the frame counter 0..`SCORE_DIV`-1. On wrap:
    - `o_score`+1, saturating at 0xFFFF.
    - The step counter advances 0..`SPEED_STEP`-1. On its wrap, `o_speed`+1, saturating at `SPEED_MAX`.
- **HIT**
  - `o_animate`=0, `o_jump`=0, `o_duck`=0.
  - Count `HIT_FRAMES` strobes, then go to OVER.
  - Button edges are ignored.
- **OVER**
  - `o_game_over`=1, `o_animate`=0.
  - `jump_edge` → pulse `o_game_rst`, clear counters, set speed=`SPEED_INIT`, go to RUN.
- **Restart pulse**
  - `jump_edge` that starts a game (IDLE or OVER) does not also produce `o_jump`.
  - `o_jump` is asserted only while already in RUN.
- **Priority:** `i_rst` > collision > score tick.

## Timing
- **Reset values:**
  - `o_state`=IDLE.
  - `o_animate`, `o_game_rst`, `o_jump`, `o_duck`, `o_game_over` = 0.
  - `o_score`=0, `o_speed`=`SPEED_INIT`, `o_hiscore`=0.
  - Synchroniser flops = 0.
- **Jump latency:** pin rises at cycle 0 → `jump_edge` at cycle 3 (2 sync flops + edge register). `o_jump` or `o_game_rst` is registered and asserted in cycle 3 for exactly 1 cycle.
- **State changes** take effect the cycle after the qualifying strobe or edge. `o_animate` follows `o_state` combinationally.
- **Score and speed** update the cycle after the `i_ani_stb` that causes them.
- **Frame strobe:** `i_ani_stb` is a one-cycle pulse. A strobe coincident with a state transition is consumed by the old state only.
- **Reset mid-game:** `i_rst` in any state returns to reset values next cycle and drops any pending pulse.

## Configuration
- **`DINO_HISCORE_EN` defined:**
  - On entry to OVER, `o_hiscore` ← max(`o_hiscore`, `o_score`), registered one cycle after entry.
  - Cleared only by `i_rst`, not by `o_game_rst`.
- **Not defined:** `o_hiscore` is tied to 0 and no comparator or register is built.

## Test plan
- Reset, then raise `i_btn_jump` → `o_game_rst`=1 for one cycle, 3 cycles after the pin rise; `o_state`=1; `o_jump` stays 0.
- In RUN, with non-overlapping boxes, send 600 strobes → `o_score`=100, `o_speed`=3.
- Set the boxes to dino 10..20 and obstacle 20..30 on x (edges touch only) → no collision. Move the obstacle to 19..30 → HIT on the next strobe, and `o_score` is unchanged on that strobe.
- In HIT, press jump → no `o_jump` and no `o_game_rst`. After 30 strobes → `o_state`=3, `o_game_over`=1.
- With `DINO_HISCORE_EN`: play game one to score 50 and game two to score 20 → `o_hiscore`=50. Without the macro, `o_hiscore` is always 0.
- Assert `i_rst` during RUN with score 37 → next cycle `o_state`=0, `o_score`=0, `o_speed`=2, all pulses 0.
